// File: rtl/beta_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// beta_rf_wb_arbiter
//
// Writeback arbiter and register scoreboard for the beta core's single write
// port register file. Up to NumReq producers request a writeback. One request
// is granted per cycle, round-robin, and the grant is latched into a registered
// output stage that drives the register file write port. A 32-entry scoreboard
// records which architectural registers still have a producer in flight. Issue
// logic uses it to stall on RAW/WAW hazards or to forward the in-flight write.
//
// Ports
//   clk_i, rstn_i      clock; asynchronous active-low reset
//   req_valid_i        per-requester writeback pending
//   req_rd_addr_i      packed 5-bit destination registers, slice i = [5i+4:5i]
//   req_wdata_i        packed write data, slice i = [DataWidth*i +: DataWidth]
//   req_ready_o        one-hot grant (combinational)
//   rf_wr_en_o         register file write enable (registered)
//   rf_rd_addr_o       register file write address (registered)
//   rf_rd_wdata_o      register file write data (registered)
//   issue_valid_i      issue stage wants to reserve issue_rd_addr_i
//   issue_rd_addr_i    destination register being reserved
//   issue_ready_o      reservation accepted this cycle
//   rs1/rs2_addr_i     source operands of the instruction in issue
//   rs1/rs2_busy_o     operand still has a producer in flight (stall)
//   rs1/rs2_fwd_o      operand available only from rf_rd_wdata_o this cycle
//   busy_o             scoreboard vector, bit 0 always 0
// -----------------------------------------------------------------------------
module beta_rf_wb_arbiter #(
   parameter int DataWidth = 32,
   parameter int NumReq    = 3
) (
   input  logic                        clk_i,
   input  logic                        rstn_i,
   input  logic [NumReq-1:0]           req_valid_i,
   input  logic [NumReq*5-1:0]         req_rd_addr_i,
   input  logic [NumReq*DataWidth-1:0] req_wdata_i,
   output logic [NumReq-1:0]           req_ready_o,
   output logic                        rf_wr_en_o,
   output logic [4:0]                  rf_rd_addr_o,
   output logic [DataWidth-1:0]        rf_rd_wdata_o,
   input  logic                        issue_valid_i,
   input  logic [4:0]                  issue_rd_addr_i,
   output logic                        issue_ready_o,
   input  logic [4:0]                  rs1_addr_i,
   input  logic [4:0]                  rs2_addr_i,
   output logic                        rs1_busy_o,
   output logic                        rs2_busy_o,
   output logic                        rs1_fwd_o,
   output logic                        rs2_fwd_o,
   output logic [31:0]                 busy_o
);

   localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
   localparam logic [PtrW-1:0] LastIdx = PtrW'(NumReq - 1);

   // Unpack the flat request buses into per-requester arrays.
   logic [4:0]           rd_arr    [NumReq];
   logic [DataWidth-1:0] wdata_arr [NumReq];

   generate
      for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
         assign rd_arr[gi]    = req_rd_addr_i[5*gi +: 5];
         assign wdata_arr[gi] = req_wdata_i[DataWidth*gi +: DataWidth];
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Round-robin arbitration
   // ---------------------------------------------------------------------
   logic [PtrW-1:0] rr_q;
   logic [PtrW-1:0] rr_next;
   logic [PtrW-1:0] grant_idx;
   logic [PtrW-1:0] cand;
   logic            grant_any;

   // Scan NumReq candidates starting at rr_q; the first valid one wins.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int off = 0; off < NumReq; off++) begin
         if (int'(rr_q) + off >= NumReq) begin
            cand = PtrW'(int'(rr_q) + off - NumReq);
         end else begin
            cand = PtrW'(int'(rr_q) + off);
         end
         if (!grant_any && req_valid_i[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   assign req_ready_o = grant_any ? (NumReq'(1) << grant_idx) : '0;

   always_comb begin
      rr_next = rr_q;
      if (grant_any) begin
         rr_next = (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------
   logic [31:0] busy_q;
   logic [31:0] clr_mask;
   logic [31:0] set_mask;
   logic [31:0] busy_set_view;
   logic [31:0] busy_next;

   // A register retiring this cycle may be reserved again in the same cycle;
   // applying the set after the clear makes the new producer win.
   assign clr_mask      = rf_wr_en_o ? (32'd1 << rf_rd_addr_o) : 32'd0;
   assign busy_set_view = busy_q & ~clr_mask;
   assign issue_ready_o = issue_valid_i &
                          ((issue_rd_addr_i == 5'd0) | ~busy_set_view[issue_rd_addr_i]);
   assign set_mask      = (issue_ready_o && (issue_rd_addr_i != 5'd0)) ?
                          (32'd1 << issue_rd_addr_i) : 32'd0;
   assign busy_next     = (busy_set_view | set_mask) & ~32'd1;

   // Operand status: a register being written this cycle is readable only
   // through the forward path, so it is reported as forwardable, not busy.
   assign rs1_fwd_o  = rf_wr_en_o & (rf_rd_addr_o == rs1_addr_i) & (rs1_addr_i != 5'd0);
   assign rs2_fwd_o  = rf_wr_en_o & (rf_rd_addr_o == rs2_addr_i) & (rs2_addr_i != 5'd0);
   assign rs1_busy_o = busy_q[rs1_addr_i] & ~rs1_fwd_o;
   assign rs2_busy_o = busy_q[rs2_addr_i] & ~rs2_fwd_o;
   assign busy_o     = busy_q;

   // ---------------------------------------------------------------------
   // State and registered write port
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rr_q          <= '0;
         busy_q        <= '0;
         rf_wr_en_o    <= 1'b0;
         rf_rd_addr_o  <= '0;
         rf_rd_wdata_o <= '0;
      end else begin
         rr_q   <= rr_next;
         busy_q <= busy_next;
         if (grant_any) begin
            // x0 writebacks take their turn but never write.
            rf_wr_en_o    <= (rd_arr[grant_idx] != 5'd0);
            rf_rd_addr_o  <= rd_arr[grant_idx];
            rf_rd_wdata_o <= wdata_arr[grant_idx];
         end else begin
            rf_wr_en_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_beta_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_beta_rf_wb_arbiter
//
// Directed scenarios with literal expectations, followed by randomized traffic.
// A behavioural model tracks the round-robin turn, the scoreboard as a bit
// array and the output stage, and is compared with the DUT every cycle.
// -----------------------------------------------------------------------------
module tb_beta_rf_wb_arbiter;

   localparam int DW = 32;
   localparam int NR = 3;

   logic             clk_i = 1'b0;
   logic             rstn_i;
   logic [NR-1:0]    req_valid_i;
   logic [NR*5-1:0]  req_rd_addr_i;
   logic [NR*DW-1:0] req_wdata_i;
   logic [NR-1:0]    req_ready_o;
   logic             rf_wr_en_o;
   logic [4:0]       rf_rd_addr_o;
   logic [DW-1:0]    rf_rd_wdata_o;
   logic             issue_valid_i;
   logic [4:0]       issue_rd_addr_i;
   logic             issue_ready_o;
   logic [4:0]       rs1_addr_i, rs2_addr_i;
   logic             rs1_busy_o, rs2_busy_o, rs1_fwd_o, rs2_fwd_o;
   logic [31:0]      busy_o;

   beta_rf_wb_arbiter #(.DataWidth(DW), .NumReq(NR)) dut (
      .clk_i           (clk_i),
      .rstn_i          (rstn_i),
      .req_valid_i     (req_valid_i),
      .req_rd_addr_i   (req_rd_addr_i),
      .req_wdata_i     (req_wdata_i),
      .req_ready_o     (req_ready_o),
      .rf_wr_en_o      (rf_wr_en_o),
      .rf_rd_addr_o    (rf_rd_addr_o),
      .rf_rd_wdata_o   (rf_rd_wdata_o),
      .issue_valid_i   (issue_valid_i),
      .issue_rd_addr_i (issue_rd_addr_i),
      .issue_ready_o   (issue_ready_o),
      .rs1_addr_i      (rs1_addr_i),
      .rs2_addr_i      (rs2_addr_i),
      .rs1_busy_o      (rs1_busy_o),
      .rs2_busy_o      (rs2_busy_o),
      .rs1_fwd_o       (rs1_fwd_o),
      .rs2_fwd_o       (rs2_fwd_o),
      .busy_o          (busy_o)
   );

   always #5 clk_i = ~clk_i;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // -------------------------------------------------------------------------
   // Behavioural model: checked on each falling edge, committed on rising edge
   // -------------------------------------------------------------------------
   int          m_rr;
   logic [31:0] m_busy;
   logic        m_en;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   logic [2:0]  mdl_grant = '0;

   initial begin : model
      int          g, idx, n_rr;
      logic [31:0] view, n_busy, n_data;
      logic        n_en, e_iss, f1, f2, b1, b2;
      logic [4:0]  n_addr, rd;
      logic [2:0]  e_ready;
      m_rr = 0; m_busy = '0; m_en = 1'b0; m_addr = '0; m_data = '0;
      forever begin
         @(negedge clk_i);
         if (!rstn_i) begin
            m_rr = 0; m_busy = '0; m_en = 1'b0; m_addr = '0; m_data = '0;
         end
         g = -1;
         for (int k = 0; k < NR; k++) begin
            idx = (m_rr + k) % NR;
            if (g < 0 && req_valid_i[idx]) g = idx;
         end
         e_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
         view = m_busy;
         if (m_en) view[m_addr] = 1'b0;
         e_iss = issue_valid_i && (issue_rd_addr_i == 5'd0 || !view[issue_rd_addr_i]);
         f1 = m_en && (m_addr == rs1_addr_i) && (rs1_addr_i != 5'd0);
         f2 = m_en && (m_addr == rs2_addr_i) && (rs2_addr_i != 5'd0);
         b1 = m_busy[rs1_addr_i] && !f1;
         b2 = m_busy[rs2_addr_i] && !f2;

         chk("m_req_ready",   32'(req_ready_o),   32'(e_ready));
         chk("m_rf_wr_en",    32'(rf_wr_en_o),    32'(m_en));
         chk("m_rf_addr",     32'(rf_rd_addr_o),  32'(m_addr));
         chk("m_rf_wdata",    rf_rd_wdata_o,      m_data);
         chk("m_issue_ready", 32'(issue_ready_o), 32'(e_iss));
         chk("m_rs1_fwd",     32'(rs1_fwd_o),     32'(f1));
         chk("m_rs2_fwd",     32'(rs2_fwd_o),     32'(f2));
         chk("m_rs1_busy",    32'(rs1_busy_o),    32'(b1));
         chk("m_rs2_busy",    32'(rs2_busy_o),    32'(b2));
         chk("m_busy_vec",    busy_o,             m_busy);

         n_rr = m_rr; n_en = 1'b0; n_addr = m_addr; n_data = m_data;
         if (g >= 0) begin
            rd     = req_rd_addr_i[5*g +: 5];
            n_rr   = (g + 1) % NR;
            n_en   = (rd != 5'd0);
            n_addr = rd;
            n_data = req_wdata_i[DW*g +: DW];
         end
         n_busy = view;
         if (e_iss && issue_rd_addr_i != 5'd0) n_busy[issue_rd_addr_i] = 1'b1;
         mdl_grant = e_ready;

         @(posedge clk_i);
         if (rstn_i) begin
            if (g >= 0) $display("grant req%0d rd=x%0d data=%h", g, n_addr, n_data);
            m_rr = n_rr; m_busy = n_busy; m_en = n_en; m_addr = n_addr; m_data = n_data;
         end else begin
            m_rr = 0; m_busy = '0; m_en = 1'b0; m_addr = '0; m_data = '0;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Stimulus
   // -------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
      req_valid_i[i]          = v;
      req_rd_addr_i[5*i +: 5] = rd;
      req_wdata_i[DW*i +: DW] = d;
   endtask

   logic [2:0]  exp_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
   logic [4:0]  exp_a [6] = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
   logic        p_v [NR];
   logic [4:0]  p_rd [NR];
   logic [31:0] p_d [NR];

   initial begin
      rstn_i = 1'b0;
      req_valid_i = '0; req_rd_addr_i = '0; req_wdata_i = '0;
      issue_valid_i = 1'b1; issue_rd_addr_i = 5'd3;
      rs1_addr_i = '0; rs2_addr_i = '0;
      for (int i = 0; i < NR; i++) begin p_v[i] = 1'b0; p_rd[i] = '0; p_d[i] = '0; end

      // Reset state
      tick(); tick();
      #1;
      chk("rst_wr_en", 32'(rf_wr_en_o), 32'd0);
      chk("rst_addr", 32'(rf_rd_addr_o), 32'd0);
      chk("rst_busy", busy_o, 32'd0);
      chk("rst_issue_ready", 32'(issue_ready_o), 32'd1);
      issue_valid_i = 1'b0;
      #2 rstn_i = 1'b1;
      tick();

      // Round-robin wrap
      set_req(0, 1'b1, 5'd1, 32'h100);
      set_req(1, 1'b1, 5'd2, 32'h200);
      set_req(2, 1'b1, 5'd3, 32'h300);
      for (int c = 0; c < 6; c++) begin
         #1;
         chk("rr_grant", 32'(req_ready_o), 32'(exp_g[c]));
         if (c > 0) chk("rr_addr", 32'(rf_rd_addr_o), 32'(exp_a[c-1]));
         tick();
      end
      req_valid_i = '0;
      #1;
      chk("rr_addr_last", 32'(rf_rd_addr_o), 32'(exp_a[5]));
      chk("rr_wr_en", 32'(rf_wr_en_o), 32'd1);
      tick();

      // x0 filtering
      set_req(1, 1'b1, 5'd0, 32'hDEADBEEF);
      #1 chk("x0_grant", 32'(req_ready_o), 32'b010);
      tick();
      set_req(1, 1'b0, 5'd0, 32'h0);
      #1;
      chk("x0_no_write", 32'(rf_wr_en_o), 32'd0);
      chk("x0_busy", busy_o, 32'd0);
      set_req(0, 1'b1, 5'd1, 32'h11);
      set_req(1, 1'b1, 5'd2, 32'h22);
      #1 chk("x0_rr_is_2", 32'(req_ready_o), 32'b001);
      tick();
      set_req(0, 1'b0, 5'd0, 32'h0);
      #1 chk("x0_rr_next", 32'(req_ready_o), 32'b010);
      tick();
      set_req(1, 1'b0, 5'd0, 32'h0);
      tick();

      // Forwarding
      issue_valid_i = 1'b1; issue_rd_addr_i = 5'd7;
      #1 chk("fwd_reserve", 32'(issue_ready_o), 32'd1);
      tick();
      issue_valid_i = 1'b0;
      #1 chk("fwd_busy7", 32'(busy_o[7]), 32'd1);
      set_req(0, 1'b1, 5'd7, 32'h1234);
      rs1_addr_i = 5'd7;
      #1;
      chk("fwd_grant", 32'(req_ready_o), 32'b001);
      chk("fwd_rs1_busy_pre", 32'(rs1_busy_o), 32'd1);
      tick();
      set_req(0, 1'b0, 5'd0, 32'h0);
      #1;
      chk("fwd_rs1_fwd", 32'(rs1_fwd_o), 32'd1);
      chk("fwd_rs1_busy", 32'(rs1_busy_o), 32'd0);
      chk("fwd_wdata", rf_rd_wdata_o, 32'h1234);
      tick();
      #1;
      chk("fwd_busy7_clr", 32'(busy_o[7]), 32'd0);
      chk("fwd_rs1_fwd_off", 32'(rs1_fwd_o), 32'd0);
      rs1_addr_i = 5'd0;

      // WAW stall
      issue_valid_i = 1'b1; issue_rd_addr_i = 5'd9;
      #1 chk("waw_first", 32'(issue_ready_o), 32'd1);
      tick();
      #1 chk("waw_stall0", 32'(issue_ready_o), 32'd0);
      tick();
      #1 chk("waw_stall1", 32'(issue_ready_o), 32'd0);
      set_req(2, 1'b1, 5'd9, 32'h99);
      #1;
      chk("waw_grant", 32'(req_ready_o), 32'b100);
      chk("waw_stall2", 32'(issue_ready_o), 32'd0);
      tick();
      set_req(2, 1'b0, 5'd0, 32'h0);
      #1;
      chk("waw_wb_en", 32'(rf_wr_en_o), 32'd1);
      chk("waw_wb_addr", 32'(rf_rd_addr_o), 32'd9);
      chk("waw_accept", 32'(issue_ready_o), 32'd1);
      tick();
      issue_valid_i = 1'b0;
      #1 chk("waw_set_wins", 32'(busy_o[9]), 32'd1);

      // Idle hold
      set_req(0, 1'b1, 5'd4, 32'hA5);
      #1 chk("idle_grant", 32'(req_ready_o), 32'b001);
      tick();
      set_req(0, 1'b0, 5'd0, 32'h0);
      #1;
      chk("idle_wr_en", 32'(rf_wr_en_o), 32'd1);
      chk("idle_wr_addr", 32'(rf_rd_addr_o), 32'd4);
      for (int c = 0; c < 4; c++) begin
         tick();
         #1;
         chk("idle_en", 32'(rf_wr_en_o), 32'd0);
         chk("idle_addr", 32'(rf_rd_addr_o), 32'd4);
         chk("idle_data", rf_rd_wdata_o, 32'hA5);
      end
      tick();

      // Reset while the x5 writeback sits in the output stage
      issue_valid_i = 1'b1; issue_rd_addr_i = 5'd5;
      tick();
      issue_valid_i = 1'b0;
      set_req(1, 1'b1, 5'd5, 32'h55);
      #1 chk("rst5_grant", 32'(req_ready_o), 32'b010);
      tick();
      set_req(1, 1'b0, 5'd0, 32'h0);
      #1;
      chk("rst5_inflight", 32'(rf_wr_en_o), 32'd1);
      chk("rst5_busy5", 32'(busy_o[5]), 32'd1);
      #1 rstn_i = 1'b0;
      #1;
      chk("rst5_en_drop", 32'(rf_wr_en_o), 32'd0);
      chk("rst5_busy_clr", busy_o, 32'd0);
      tick(); tick();
      #1 rstn_i = 1'b1;
      tick();
      #1;
      chk("rst5_no_write", 32'(rf_wr_en_o), 32'd0);
      chk("rst5_addr", 32'(rf_rd_addr_o), 32'd0);
      chk("rst5_data", rf_rd_wdata_o, 32'd0);

      // Randomized traffic; requesters hold their request until granted
      for (int cyc = 0; cyc < 1200; cyc++) begin
         for (int i = 0; i < NR; i++) begin
            if (p_v[i] && mdl_grant[i]) p_v[i] = 1'b0;
            if (!p_v[i] && $urandom_range(2, 0) == 0) begin
               p_v[i]  = 1'b1;
               p_rd[i] = 5'($urandom_range(15, 0));
               p_d[i]  = $urandom;
            end
            set_req(i, p_v[i], p_rd[i], p_d[i]);
         end
         issue_valid_i   = 1'($urandom_range(1, 0));
         issue_rd_addr_i = 5'($urandom_range(15, 0));
         rs1_addr_i      = 5'($urandom_range(15, 0));
         rs2_addr_i      = 5'($urandom_range(15, 0));
         if (cyc == 600) begin
            #2 rstn_i = 1'b0;
            #4 rstn_i = 1'b1;
         end
         tick();
      end

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
